frame_sender: RTL and testbench

FRAME_SENDER -- requirements
Module: frame_sender

---
 rtl/frame_sender.sv | 123 ++++++++++++
 tb/tb_frame_sender.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sender.sv
// frame_sender: buffers fast and slow payload bytes and serializes them as a strobed frame.
module frame_sender #(
    parameter int BYTES    = 16,
    parameter int STROB_HI = 2,
    parameter int GAP      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] fData,
    input  logic        fVal,
    input  logic [11:0] sData,
    input  logic        sVal,
    input  logic [10:0] sAddr,
    input  logic        start,
    output logic [7:0]  oData,
    output logic        strob,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        unf
);
    localparam int CW = $clog2(BYTES + 1);
    localparam int AW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int IW = $clog2(BYTES + 2);
    localparam int TW = $clog2((STROB_HI > GAP ? STROB_HI : GAP) + 1);
    typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, DONE} state_t;
    state_t        state_q;
    logic [7:0]    mem_q [BYTES];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q;
    logic [TW-1:0] tm_q;
    logic [9:0]    pend_q, tx_q, slow;
    logic          pv_q, fast, pop, push;
    logic [7:0]    byte_d;
    logic          unused;
    assign unused = ^{fData[11], fData[2:0], sData[11], sData[0]};
    always_comb begin
        fast   = idx_q < IW'(BYTES);
        pop    = state_q == LOAD && fast && cnt_q != '0;
        push   = fVal && (cnt_q != CW'(BYTES) || pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        slow   = sAddr == '0 ? '0 : tx_q;
        byte_d = fast ? (pop ? mem_q[rd_q] : 8'h00) :
                 idx_q == IW'(BYTES) ? slow[7:0] : {6'b0, slow[9:8]};
    end
    // a pop in the same cycle frees the slot a write into a full buffer needs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= fData[10:3];
                wr_q        <= wr_q == AW'(BYTES - 1) ? '0 : wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q == AW'(BYTES - 1) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_d;
            if (fVal && !push) ovf <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tm_q    <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            tx_q    <= '0;
            oData   <= 8'h00;
            strob   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            unf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= LOAD;
                    idx_q   <= '0;
                    tx_q    <= pv_q ? pend_q : '0;
                    pv_q    <= 1'b0;
                    busy    <= 1'b1;
                end
                LOAD: begin
                    oData   <= byte_d;
                    strob   <= 1'b1;
                    tm_q    <= '0;
                    state_q <= HIGH;
                    if (fast && cnt_q == '0) unf <= 1'b1;
                end
                HIGH: if (tm_q == TW'(STROB_HI - 1)) begin
                    strob   <= 1'b0;
                    tm_q    <= '0;
                    state_q <= LOW;
                end else begin
                    tm_q <= tm_q + 1'b1;
                end
                LOW: if (tm_q != TW'(GAP - 1)) begin
                    tm_q <= tm_q + 1'b1;
                end else if (idx_q == IW'(BYTES + 1)) begin
                    done    <= 1'b1;
                    state_q <= DONE;
                end else begin
                    idx_q   <= idx_q + 1'b1;
                    state_q <= LOAD;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // a new slow word always lands in the pending register, even on the start cycle
            if (sVal) begin
                pend_q <= sData[10:1];
                pv_q   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: randomized frame checks against a queue-based model of the frame rules.
module tb_frame_sender;
    localparam int BYTES = 16, SH = 2, GP = 4, NB = BYTES + 2;
    logic clk = 0, rst = 1;
    logic [11:0] fData = '0, sData = '0;
    logic fVal = 0, sVal = 0, start = 0;
    logic [10:0] sAddr = '0;
    logic [7:0] oData;
    logic strob, busy, done, ovf, unf;
    int vec = 0, err = 0;
    logic [7:0] fq[$];
    logic [9:0] pend = '0;
    bit pv = 0, m_ovf = 0, m_unf = 0;

    always #5 clk = ~clk;

    frame_sender dut (
        .clk(clk), .rst(rst), .fData(fData), .fVal(fVal), .sData(sData), .sVal(sVal),
        .sAddr(sAddr), .start(start), .oData(oData), .strob(strob), .busy(busy),
        .done(done), .ovf(ovf), .unf(unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; fVal = 0; sVal = 0; start = 0;
        tick();
        tick();
        rst = 0;
        fq.delete();
        pv = 0; pend = '0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic write_fast(input logic [7:0] b);
        fData = {1'($urandom), b, 3'($urandom)};
        fVal = 1;
        tick();
        fVal = 0;
        if (fq.size() < BYTES) fq.push_back(b);
        else m_ovf = 1;
    endtask

    task automatic write_slow(input logic [9:0] w);
        sData = {1'($urandom), w, 1'($urandom)};
        sVal = 1;
        tick();
        sVal = 0;
        pend = w; pv = 1;
    endtask

    // mid_s: slow word written mid-frame; mid_f: fast word written during the first pop (only with a full buffer)
    task automatic run_frame(input logic [10:0] addr, input bit timing, input bit mid_s,
                             input logic [9:0] mid_w, input bit mid_f, input logic [7:0] mid_fb);
        logic [7:0] exp_b[NB];
        logic [7:0] got[NB];
        logic [9:0] sl;
        int n, dn, hi, last;
        bit sp, fin;
        for (int i = 0; i < BYTES; i++) begin
            if (fq.size() > 0) exp_b[i] = fq.pop_front();
            else begin exp_b[i] = 8'h00; m_unf = 1; end
        end
        sl = pv ? pend : 10'h0;
        pv = 0;
        exp_b[BYTES]   = addr == 0 ? 8'h00 : sl[7:0];
        exp_b[BYTES+1] = addr == 0 ? 8'h00 : {6'b0, sl[9:8]};
        if (mid_s) begin pend = mid_w; pv = 1; end
        if (mid_f) fq.push_back(mid_fb);
        n = 0; dn = 0; hi = 0; last = 0; sp = 0; fin = 0;
        foreach (got[i]) got[i] = 8'h00;
        sAddr = addr;
        start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(negedge clk);
            if (k == 1 && mid_f) begin fData = {1'b0, mid_fb, 3'b0}; fVal = 1; end
            if (k == 2) fVal = 0;
            if (k == 10 && mid_s) begin sData = {1'b1, mid_w, 1'b1}; sVal = 1; end
            if (k == 11) sVal = 0;
            if (k == 1 && timing) begin
                vec++;
                if (busy !== 1'b1) begin err++; $display("FAIL busy_load: got %b want 1", busy); end
            end
            if (strob && !sp) begin
                if (n < NB) got[n] = oData;
                if (timing) begin
                    vec++;
                    if (k != (n == 0 ? 2 : last + 1 + SH + GP)) begin
                        err++; $display("FAIL strob_rise[%0d]: got cycle %0d want %0d", n, k, n == 0 ? 2 : last + 1 + SH + GP);
                    end
                end
                last = k;
                n++;
            end
            if (strob) hi++;
            else begin
                if (sp && timing) begin
                    vec++;
                    if (hi != SH) begin err++; $display("FAIL strob_high: got %0d cycles want %0d", hi, SH); end
                end
                hi = 0;
            end
            if (done) begin
                dn++;
                fin = 1;
                if (timing) begin
                    vec++;
                    if (k != 1 + NB * (1 + SH + GP)) begin
                        err++; $display("FAIL done_time: got cycle %0d want %0d", k, 1 + NB * (1 + SH + GP));
                    end
                end
            end
            sp = strob;
        end
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        vec++;
        if (n != NB) begin err++; $display("FAIL strobe_count: got %0d want %0d", n, NB); end
        for (int i = 0; i < NB; i++) begin
            vec++;
            if (got[i] !== exp_b[i]) begin err++; $display("FAIL byte[%0d]: got %h want %h", i, got[i], exp_b[i]); end
        end
        vec++;
        if (dn != 1) begin err++; $display("FAIL done_count: got %0d want 1", dn); end
        vec++;
        if (busy !== 1'b0) begin err++; $display("FAIL busy_end: got %b want 0", busy); end
        vec++;
        if (ovf !== m_ovf) begin err++; $display("FAIL ovf: got %b want %b", ovf, m_ovf); end
        vec++;
        if (unf !== m_unf) begin err++; $display("FAIL unf: got %b want %b", unf, m_unf); end
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({oData, strob, busy, done, ovf, unf} !== 13'h0) begin
            err++; $display("FAIL reset_outputs: got %h want 0000", {oData, strob, busy, done, ovf, unf});
        end
    endtask

    task automatic test_empty_frame();
        do_reset();
        run_frame(11'h3, 0, 0, '0, 0, '0);
    endtask

    task automatic test_nominal();
        logic [9:0] w;
        do_reset();
        for (int b = 1; b <= 16; b++) write_fast(8'(b));
        write_slow(10'h2A5);
        w = 10'($urandom);
        run_frame(11'h005, 1, 1, w, 0, '0);
        run_frame(11'h005, 0, 0, '0, 0, '0);
    endtask

    task automatic test_saddr_zero();
        do_reset();
        for (int b = 1; b <= 16; b++) write_fast(8'(b));
        write_slow(10'h2A5);
        run_frame(11'h000, 0, 0, '0, 0, '0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 17; i++) write_fast(8'($urandom));
        run_frame(11'h7FF, 0, 0, '0, 0, '0);
    endtask

    task automatic test_underflow();
        do_reset();
        for (int i = 0; i < 3; i++) write_fast(8'($urandom));
        write_slow(10'($urandom));
        run_frame(11'h001, 0, 0, '0, 0, '0);
    endtask

    task automatic test_push_at_pop();
        do_reset();
        for (int i = 0; i < 16; i++) write_fast(8'($urandom));
        run_frame(11'h002, 0, 0, '0, 1, 8'($urandom));
        run_frame(11'h002, 0, 0, '0, 0, '0);
    endtask

    task automatic test_reset_midframe();
        int n, dn;
        bit sp, hit;
        do_reset();
        for (int i = 0; i < 16; i++) write_fast(8'($urandom));
        write_slow(10'($urandom));
        sAddr = 11'h001;
        start = 1;
        tick();
        start = 0;
        n = 0; sp = 0; hit = 0; dn = 0;
        for (int k = 1; k <= 100 && !hit; k++) begin
            @(negedge clk);
            if (strob && !sp) begin
                n++;
                if (n == 5) hit = 1;
            end
            sp = strob;
        end
        vec++;
        if (!hit) begin err++; $display("FAIL reach_byte5: got %0d strobes want 5", n); end
        rst = 1;
        @(negedge clk);
        vec++;
        if ({strob, busy, done, oData} !== 11'h0) begin
            err++; $display("FAIL abort: got strob=%b busy=%b done=%b oData=%h want 0", strob, busy, done, oData);
        end
        rst = 0;
        fq.delete();
        pv = 0; pend = '0; m_ovf = 0; m_unf = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dn++;
        end
        vec++;
        if (dn != 0) begin err++; $display("FAIL abort_done: got %0d pulses want 0", dn); end
        for (int i = 0; i < 16; i++) write_fast(8'($urandom));
        write_slow(10'($urandom));
        run_frame(11'h004, 1, 0, '0, 0, '0);
    endtask

    task automatic test_random();
        int nw;
        logic [10:0] a;
        do_reset();
        repeat (6) begin
            nw = $urandom_range(0, 18);
            for (int i = 0; i < nw; i++) write_fast(8'($urandom));
            if ($urandom_range(0, 3) != 0) write_slow(10'($urandom));
            a = ($urandom_range(0, 2) == 0) ? 11'h0 : 11'($urandom_range(1, 2047));
            run_frame(a, 1, 1'($urandom), 10'($urandom), 0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_nominal();
        test_saddr_zero();
        test_overflow();
        test_underflow();
        test_push_at_pop();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
